operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 189 ++++++++++++++++++
 tb/tb_operand_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: clears the north/west lane buffers, then streams 2*G*K operands
// into them with a diagonal skew (addr = lane + k), then runs the PE grid for
// K + 2*G - 1 cycles and pulses done.
module operand_loader #(
  parameter  int NUM_SIZE   = 16,
  parameter  int BUFFER_LEN = 8,
  parameter  int GRID_SIZE  = 2,
  localparam int AW = $clog2(BUFFER_LEN),
  localparam int LW = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1,
  localparam int KW = AW + 1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KW-1:0]       cfg_k,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_SIZE-1:0] in_data,
  output logic                wr_en,
  output logic                wr_sel,
  output logic [LW-1:0]       wr_lane,
  output logic [AW-1:0]       wr_addr,
  output logic [NUM_SIZE-1:0] wr_data,
  output logic                ce,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // run counter is wide enough for K + 2*G - 2
  localparam int RW = KW + LW + 2;

  localparam logic [LW-1:0] LAST_LANE = LW'(GRID_SIZE - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BUFFER_LEN - 1);
  localparam logic [KW-1:0] KMAX      = KW'(BUFFER_LEN - GRID_SIZE + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [KW-1:0] k_reg;
  logic          c_sel;
  logic [LW-1:0] c_lane;
  logic [AW-1:0] c_addr;    // clear position currently on the write port
  logic [KW-1:0] c_k;       // next element index within the lane
  logic          load_fin;  // last operand accepted, its write is in flight
  logic [RW-1:0] run_cnt;

  logic          nx_sel;
  logic [LW-1:0] nx_lane;
  logic [AW-1:0] nx_addr;
  logic          clear_last;
  logic          load_last;
  logic          k_ok;
  logic [RW-1:0] run_last;

  // Operands are only taken while loading and before the final one is accepted.
  assign in_ready = (state == S_LOAD) && !load_fin;

  assign k_ok       = (cfg_k != '0) && (cfg_k <= KMAX);
  assign clear_last = c_sel && (c_lane == LAST_LANE) && (c_addr == LAST_ADDR);
  assign load_last  = c_sel && (c_lane == LAST_LANE) && (c_k == k_reg - 1'b1);
  assign run_last   = RW'(k_reg) + RW'(2 * GRID_SIZE - 2);

  // Next clear position: addr fastest, then lane, then north->west.
  always_comb begin
    nx_sel  = c_sel;
    nx_lane = c_lane;
    nx_addr = c_addr + 1'b1;
    if (c_addr == LAST_ADDR) begin
      nx_addr = '0;
      if (c_lane == LAST_LANE) begin
        nx_lane = '0;
        nx_sel  = 1'b1;
      end else begin
        nx_lane = c_lane + 1'b1;
      end
    end
  end

  // Control FSM with registered outputs; strobes default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      k_reg    <= '0;
      c_sel    <= 1'b0;
      c_lane   <= '0;
      c_addr   <= '0;
      c_k      <= '0;
      load_fin <= 1'b0;
      run_cnt  <= '0;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_lane  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      ce       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (k_ok) begin
              // first clear write is presented in the first CLEAR cycle
              k_reg   <= cfg_k;
              state   <= S_CLEAR;
              busy    <= 1'b1;
              c_sel   <= 1'b0;
              c_lane  <= '0;
              c_addr  <= '0;
              wr_en   <= 1'b1;
              wr_sel  <= 1'b0;
              wr_lane <= '0;
              wr_addr <= '0;
              wr_data <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (clear_last) begin
            state    <= S_LOAD;
            c_sel    <= 1'b0;
            c_lane   <= '0;
            c_k      <= '0;
            load_fin <= 1'b0;
          end else begin
            c_sel   <= nx_sel;
            c_lane  <= nx_lane;
            c_addr  <= nx_addr;
            wr_en   <= 1'b1;
            wr_sel  <= nx_sel;
            wr_lane <= nx_lane;
            wr_addr <= nx_addr;
            wr_data <= '0;
          end
        end
        S_LOAD: begin
          if (load_fin) begin
            // final write has issued this cycle; start computing
            state    <= S_RUN;
            load_fin <= 1'b0;
            ce       <= 1'b1;
            run_cnt  <= '0;
          end else if (in_valid) begin
            wr_en   <= 1'b1;
            wr_sel  <= c_sel;
            wr_lane <= c_lane;
            wr_addr <= AW'(c_lane) + AW'(c_k);
            wr_data <= in_data;
            if (load_last) begin
              load_fin <= 1'b1;
            end else if (c_k == k_reg - 1'b1) begin
              c_k <= '0;
              if (c_lane == LAST_LANE) begin
                c_lane <= '0;
                c_sel  <= 1'b1;
              end else begin
                c_lane <= c_lane + 1'b1;
              end
            end else begin
              c_k <= c_k + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (run_cnt == run_last) begin
            ce    <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader (G=2, BL=8, 16-bit operands).
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  cfg_k = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        wr_en, wr_sel, ce, busy, done, err;
  logic [0:0]  wr_lane;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  int passed = 0;
  int checks = 0;

  // write/strobe observer state
  logic [15:0] mem [2][2][8];
  int n_wr, n_nz, n_ce, n_ovl, n_done, n_err;
  logic [15:0] vals [8];

  operand_loader #(.NUM_SIZE(16), .BUFFER_LEN(8), .GRID_SIZE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane), .wr_addr(wr_addr),
    .wr_data(wr_data), .ce(ce), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // observe outputs mid-cycle
  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_sel][wr_lane][wr_addr] = wr_data;
      n_wr++;
      if (wr_data != 0) n_nz++;
    end
    if (ce) n_ce++;
    if (ce && wr_en) n_ovl++;
    if (done) n_done++;
    if (err) n_err++;
  end

  // expected buffer content after a job with inner dimension k
  function automatic logic [15:0] exp_val(int s, int l, int a, int k);
    if (a >= l && a - l < k) return vals[s*2*k + l*k + (a - l)];
    return 16'h0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        for (int a = 0; a < 8; a++) mem[s][l][a] = 16'hDEAD;
    n_wr = 0; n_nz = 0; n_ce = 0; n_ovl = 0; n_done = 0; n_err = 0;
  endtask

  task automatic do_start(input logic [3:0] k);
    start = 1'b1; cfg_k = k;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int c = 0;
    while (!in_ready && c < 200) begin tick(); c++; end
    ok = in_ready;
  endtask

  task automatic feed(input int n, input bit toggle, output bit ok);
    int i = 0;
    int cyc = 0;
    bit acc;
    while (i < n && cyc < 200) begin
      in_valid = toggle ? cyc[0] : 1'b1;
      in_data  = vals[i];
      acc = in_ready && in_valid;
      tick();
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    ok = (i == n);
  endtask

  task automatic wait_idle(output bit ok);
    int c = 0;
    while (busy && c < 200) begin tick(); c++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, ce, busy, done, err, in_ready} !== 6'b0) $display("FAIL reset_strobes got=%b want=000000", {wr_en, ce, busy, done, err, in_ready});
    else passed++;
    checks++;
    if ({wr_sel, wr_lane, wr_addr, wr_data} !== 21'b0) $display("FAIL reset_wr_fields got=%h want=0", {wr_sel, wr_lane, wr_addr, wr_data});
    else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic run_k2(input bit toggle, input string tag);
    bit ok;
    int bad;
    vals = '{16'd2, 16'd7, 16'd1, 16'd8, 16'd3, 16'd1, 16'd4, 16'd1};
    clr_mon();
    do_start(4'd2);
    checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy got=%b want=1", tag, busy); else passed++;
    wait_ready(ok);
    checks++;
    if (!ok || n_wr != 32 || n_nz != 0) $display("FAIL %s_clear ready=%0d writes=%0d nonzero=%0d want 1/32/0", tag, ok, n_wr, n_nz);
    else passed++;
    bad = 0;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        for (int a = 0; a < 8; a++) if (mem[s][l][a] !== 16'h0) bad++;
    checks++;
    if (bad != 0) $display("FAIL %s_clear_cover uncleared=%0d want=0", tag, bad); else passed++;
    feed(8, toggle, ok);
    wait_idle(ok);
    checks++;
    if (!ok || n_wr != 40 || n_nz != 8) $display("FAIL %s_writes idle=%0d writes=%0d nonzero=%0d want 1/40/8", tag, ok, n_wr, n_nz);
    else passed++;
    bad = 0;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        for (int a = 0; a < 8; a++) if (mem[s][l][a] !== exp_val(s, l, a, 2)) bad++;
    checks++;
    if (bad != 0) $display("FAIL %s_buffer wrong_entries=%0d want=0", tag, bad); else passed++;
    checks++;
    if (n_ce != 5 || n_done != 1 || n_ovl != 0 || n_err != 0)
      $display("FAIL %s_run ce=%0d done=%0d overlap=%0d err=%0d want 5/1/0/0", tag, n_ce, n_done, n_ovl, n_err);
    else passed++;
  endtask

  task automatic test_basic();
    run_k2(1'b0, "basic");
  endtask

  task automatic test_toggle();
    run_k2(1'b1, "toggle");
  endtask

  task automatic test_bad_k();
    clr_mon();
    do_start(4'd0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL badk0 err=%b busy=%b want err=1 busy=0", err, busy); else passed++;
    tick();
    checks++;
    if (err !== 1'b0) $display("FAIL badk0_pulse err=%b want=0", err); else passed++;
    do_start(4'd8);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL badk8 err=%b busy=%b want err=1 busy=0", err, busy); else passed++;
    tick(); tick();
    checks++;
    if (n_err != 2 || n_wr != 0 || busy !== 1'b0) $display("FAIL badk_total errs=%0d writes=%0d busy=%b want 2/0/0", n_err, n_wr, busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    vals = '{16'd2, 16'd7, 16'd1, 16'd8, 16'd3, 16'd1, 16'd4, 16'd1};
    clr_mon();
    do_start(4'd2);
    wait_ready(ok);
    // third accepted operand is on the write port after this
    feed(3, 1'b0, ok);
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, ce, busy, done, err, in_ready} !== 6'b0 || wr_data !== 16'h0)
      $display("FAIL midrst_outputs got=%b data=%h want=000000/0", {wr_en, ce, busy, done, err, in_ready}, wr_data);
    else passed++;
    tick(); tick();
    checks++;
    if (n_ce != 0 || n_nz != 2) $display("FAIL midrst_abort ce=%0d nonzero_writes=%0d want 0/2", n_ce, n_nz); else passed++;
    vals = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h0, 16'h0, 16'h0, 16'h0};
    clr_mon();
    start = 1'b1; cfg_k = 4'd1;
    rst = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL midrst_restart busy=%b want=1", busy); else passed++;
    wait_ready(ok);
    feed(4, 1'b0, ok);
    wait_idle(ok);
    bad = 0;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        for (int a = 0; a < 8; a++) if (mem[s][l][a] !== exp_val(s, l, a, 1)) bad++;
    checks++;
    if (!ok || bad != 0 || n_wr != 36) $display("FAIL k1_buffer idle=%0d wrong=%0d writes=%0d want 1/0/36", ok, bad, n_wr);
    else passed++;
    checks++;
    if (n_ce != 4 || n_done != 1) $display("FAIL k1_run ce=%0d done=%0d want 4/1", n_ce, n_done); else passed++;
  endtask

  task automatic test_start_held();
    bit ok;
    int c;
    vals = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
    clr_mon();
    start = 1'b1; cfg_k = 4'd2;
    tick();
    wait_ready(ok);
    feed(8, 1'b0, ok);
    c = 0;
    while (!done && c < 200) begin tick(); c++; end
    checks++;
    if (done !== 1'b1 || n_ce != 5) $display("FAIL held_done done=%b ce=%0d want 1/5", done, n_ce); else passed++;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL held_idle busy=%b done=%b want 0/0", busy, done); else passed++;
    tick();
    checks++;
    if (busy !== 1'b1 || n_done != 1 || n_err != 0) $display("FAIL held_rejob busy=%b done=%0d err=%0d want 1/1/0", busy, n_done, n_err);
    else passed++;
    start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic test_valid_outside();
    bit ok;
    int c;
    int bad;
    vals = '{16'h55, 16'h55, 16'h55, 16'h55, 16'h0, 16'h0, 16'h0, 16'h0};
    clr_mon();
    in_valid = 1'b1; in_data = 16'h55;
    do_start(4'd1);
    tick();
    checks++;
    if (in_ready !== 1'b0 || n_nz != 0) $display("FAIL clear_ready in_ready=%b nonzero=%0d want 0/0", in_ready, n_nz); else passed++;
    c = 0; bad = 0;
    while (busy && c < 200) begin
      if (ce && in_ready) bad++;
      tick(); c++;
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || bad != 0 || n_wr != 36 || n_nz != 4)
      $display("FAIL outside_valid busy=%b ready_in_run=%0d writes=%0d nonzero=%0d want 0/0/36/4", busy, bad, n_wr, n_nz);
    else passed++;
    bad = 0;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 2; l++)
        for (int a = 0; a < 8; a++) if (mem[s][l][a] !== exp_val(s, l, a, 1)) bad++;
    checks++;
    if (bad != 0 || n_ce != 4) $display("FAIL outside_buffer wrong=%0d ce=%0d want 0/4", bad, n_ce); else passed++;
    tick(); tick();
    checks++;
    if (n_wr != 36 || in_ready !== 1'b0) $display("FAIL idle_valid writes=%0d in_ready=%b want 36/0", n_wr, in_ready); else passed++;
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_basic();
    test_toggle();
    test_bad_k();
    test_reset_mid();
    test_start_held();
    test_valid_outside();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
